// File: rtl/fir_xifu_mem_responder_if.sv
// fir_xifu_mem_responder_if: XIF mem/mem_result plus OBI data port bundle for the responder
interface fir_xifu_mem_responder_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int ID_WIDTH   = 4
);
  logic                  clear_i;
  logic                  mem_valid_i;
  logic                  mem_ready_o;
  logic [ID_WIDTH-1:0]   mem_id_i;
  logic [ADDR_WIDTH-1:0] mem_addr_i;
  logic                  mem_we_i;
  logic [2:0]            mem_size_i;
  logic [3:0]            mem_be_i;
  logic [31:0]           mem_wdata_i;
  logic                  mem_resp_exc_o;
  logic [5:0]            mem_resp_exccode_o;
  logic                  mem_result_valid_o;
  logic [ID_WIDTH-1:0]   mem_result_id_o;
  logic [31:0]           mem_result_rdata_o;
  logic                  mem_result_err_o;
  logic                  obi_req_o;
  logic                  obi_gnt_i;
  logic [ADDR_WIDTH-1:0] obi_addr_o;
  logic                  obi_we_o;
  logic [3:0]            obi_be_o;
  logic [31:0]           obi_wdata_o;
  logic                  obi_rvalid_i;
  logic [31:0]           obi_rdata_i;
  logic                  obi_err_i;
  logic                  spurious_o;
  modport slave (
    input  clear_i, mem_valid_i, mem_id_i, mem_addr_i, mem_we_i, mem_size_i, mem_be_i, mem_wdata_i,
           obi_gnt_i, obi_rvalid_i, obi_rdata_i, obi_err_i,
    output mem_ready_o, mem_resp_exc_o, mem_resp_exccode_o, mem_result_valid_o, mem_result_id_o,
           mem_result_rdata_o, mem_result_err_o, obi_req_o, obi_addr_o, obi_we_o, obi_be_o,
           obi_wdata_o, spurious_o
  );
  modport master (
    output clear_i, mem_valid_i, mem_id_i, mem_addr_i, mem_we_i, mem_size_i, mem_be_i, mem_wdata_i,
           obi_gnt_i, obi_rvalid_i, obi_rdata_i, obi_err_i,
    input  mem_ready_o, mem_resp_exc_o, mem_resp_exccode_o, mem_result_valid_o, mem_result_id_o,
           mem_result_rdata_o, mem_result_err_o, obi_req_o, obi_addr_o, obi_we_o, obi_be_o,
           obi_wdata_o, spurious_o
  );
endinterface

// File: rtl/fir_xifu_mem_responder.sv
// fir_xifu_mem_responder: checks XIF memory requests, forwards legal ones to OBI, returns results in order
module fir_xifu_mem_responder #(
  parameter int                    ADDR_WIDTH      = 32,
  parameter int                    DATA_WIDTH      = 32,
  parameter int                    ID_WIDTH        = 4,
  parameter int                    MAX_OUTSTANDING = 2,
  parameter logic [ADDR_WIDTH-1:0] PMA_BASE        = 32'h1000_0000,
  parameter logic [ADDR_WIDTH-1:0] PMA_SIZE        = 32'h0001_0000
) (
  input logic clk_i,
  input logic rst_ni,
  fir_xifu_mem_responder_if.slave bus
);
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam int PW = MAX_OUTSTANDING > 1 ? $clog2(MAX_OUTSTANDING) : 1;
  localparam logic [ADDR_WIDTH:0] LO = {1'b0, PMA_BASE};
  localparam logic [ADDR_WIDTH:0] HI = LO + {1'b0, PMA_SIZE};

  logic [ID_WIDTH-1:0] fid_q [MAX_OUTSTANDING];
  logic                fwe_q [MAX_OUTSTANDING];
  logic [CW-1:0]       count_q, count_d;
  logic [PW-1:0]       wptr_q, wptr_d, rptr_q, rptr_d;
  logic                res_valid_q, res_err_q, spurious_q, spurious_d;
  logic [ID_WIDTH-1:0] res_id_q;
  logic [31:0]         res_rdata_q;
  logic                mis, oor, fault, full, empty, push, pop, flush;

  // Alignment/range fault check; misalignment (including bad sizes) wins over range.
  assign mis = !(bus.mem_size_i inside {3'd1, 3'd2, 3'd4}) ||
               (bus.mem_size_i == 3'd2 && bus.mem_addr_i[0]) ||
               (bus.mem_size_i == 3'd4 && bus.mem_addr_i[1:0] != 2'b00);
  assign oor   = {1'b0, bus.mem_addr_i} < LO || {1'b0, bus.mem_addr_i} >= HI;
  assign fault = bus.mem_valid_i && (mis || oor);
  assign full  = count_q == CW'(MAX_OUTSTANDING);
  assign empty = count_q == '0;
  assign push  = bus.obi_req_o && bus.obi_gnt_i;
  assign pop   = bus.obi_rvalid_i && !empty;
  assign flush = !rst_ni || bus.clear_i;

  assign bus.obi_req_o          = bus.mem_valid_i && !full && !fault;
  assign bus.mem_ready_o        = fault || push;
  assign bus.mem_resp_exc_o     = fault;
  assign bus.mem_resp_exccode_o = !fault ? 6'd0 : mis ? (bus.mem_we_i ? 6'd6 : 6'd4) : (bus.mem_we_i ? 6'd7 : 6'd5);
  assign bus.obi_addr_o         = {bus.mem_addr_i[ADDR_WIDTH-1:2], 2'b00};
  assign bus.obi_we_o           = bus.mem_we_i;
  assign bus.obi_be_o           = bus.mem_be_i;
  assign bus.obi_wdata_o        = bus.mem_wdata_i;
  assign bus.mem_result_valid_o = res_valid_q;
  assign bus.mem_result_id_o    = res_id_q;
  assign bus.mem_result_rdata_o = res_rdata_q;
  assign bus.mem_result_err_o   = res_err_q;
  assign bus.spurious_o         = spurious_q;

  // Next-state for the outstanding-transaction FIFO bookkeeping and the sticky spurious flag.
  always_comb begin
    count_d    = count_q + CW'(push) - CW'(pop);
    wptr_d     = push ? (wptr_q == PW'(MAX_OUTSTANDING - 1) ? '0 : wptr_q + 1'b1) : wptr_q;
    rptr_d     = pop ? (rptr_q == PW'(MAX_OUTSTANDING - 1) ? '0 : rptr_q + 1'b1) : rptr_q;
    spurious_d = spurious_q || (bus.obi_rvalid_i && empty);
  end

  // FIFO payload storage needs no reset; validity is tracked by the count.
  always_ff @(posedge clk_i) begin
    if (push) begin
      fid_q[wptr_q] <= bus.mem_id_i;
      fwe_q[wptr_q] <= bus.mem_we_i;
    end
  end

  // State registers and the one-cycle-delayed result; clear_i behaves exactly like reset.
  always_ff @(posedge clk_i) begin
    if (flush) begin
      count_q     <= '0;
      wptr_q      <= '0;
      rptr_q      <= '0;
      spurious_q  <= 1'b0;
      res_valid_q <= 1'b0;
      res_id_q    <= '0;
      res_rdata_q <= '0;
      res_err_q   <= 1'b0;
    end else begin
      count_q     <= count_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      spurious_q  <= spurious_d;
      res_valid_q <= pop;
      if (pop) begin
        res_id_q    <= fid_q[rptr_q];
        res_rdata_q <= fwe_q[rptr_q] ? 32'd0 : bus.obi_rdata_i;
        res_err_q   <= bus.obi_err_i;
      end
    end
  end
endmodule

// File: tb/tb_fir_xifu_mem_responder.sv
// tb_fir_xifu_mem_responder: scoreboard bench for the XIF memory responder
module tb_fir_xifu_mem_responder;
  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] rdata;
    logic        err;
  } res_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;
  res_t sb [$];

  fir_xifu_mem_responder_if #(.ADDR_WIDTH(32), .ID_WIDTH(4)) bus ();

  fir_xifu_mem_responder dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.clear_i = 0; bus.mem_valid_i = 0; bus.mem_id_i = 0; bus.mem_addr_i = 0; bus.mem_we_i = 0;
    bus.mem_size_i = 0; bus.mem_be_i = 0; bus.mem_wdata_i = 0; bus.obi_gnt_i = 0;
    bus.obi_rvalid_i = 0; bus.obi_rdata_i = 0; bus.obi_err_i = 0;
  endtask

  task automatic req(input logic [3:0] id, input logic [31:0] addr, input logic we,
                     input logic [2:0] size, input logic [3:0] be, input logic [31:0] wdata);
    bus.mem_valid_i = 1; bus.mem_id_i = id; bus.mem_addr_i = addr; bus.mem_we_i = we;
    bus.mem_size_i = size; bus.mem_be_i = be; bus.mem_wdata_i = wdata;
  endtask

  task automatic rsp(input logic v, input logic [31:0] rdata, input logic err);
    bus.obi_rvalid_i = v; bus.obi_rdata_i = rdata; bus.obi_err_i = err;
  endtask

  // Every result the DUT emits is matched against the oldest expected entry.
  always @(negedge clk) begin
    if (rst_n && bus.mem_result_valid_o) begin
      if (sb.size() == 0) chk("unexpected_result", 64'(bus.mem_result_id_o), 64'hFFFF);
      else begin
        res_t e;
        e = sb.pop_front();
        chk("res_id", 64'(bus.mem_result_id_o), 64'(e.id));
        chk("res_rdata", 64'(bus.mem_result_rdata_o), 64'(e.rdata));
        chk("res_err", 64'(bus.mem_result_err_o), 64'(e.err));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    cycle(); cycle();
    rst_n = 1;
    #1;
    chk("rst_valid", 64'(bus.mem_result_valid_o), 0);
    chk("rst_id", 64'(bus.mem_result_id_o), 0);
    chk("rst_rdata", 64'(bus.mem_result_rdata_o), 0);
    chk("rst_err", 64'(bus.mem_result_err_o), 0);
    chk("rst_spurious", 64'(bus.spurious_o), 0);
    chk("rst_req", 64'(bus.obi_req_o), 0);

    // Single load, zero-wait OBI: result two cycles after the request.
    cycle();
    req(3, 32'h1000_0004, 0, 4, 4'hF, 0);
    bus.obi_gnt_i = 1;
    #1;
    chk("ld_ready", 64'(bus.mem_ready_o), 1);
    chk("ld_req", 64'(bus.obi_req_o), 1);
    chk("ld_exc", 64'(bus.mem_resp_exc_o), 0);
    chk("ld_addr", 64'(bus.obi_addr_o), 64'h1000_0004);
    sb.push_back('{4'd3, 32'hDEAD_BEEF, 1'b0});
    cycle();
    idle();
    rsp(1, 32'hDEAD_BEEF, 0);
    #1;
    chk("ld_lat1_valid", 64'(bus.mem_result_valid_o), 0);
    cycle();
    rsp(0, 0, 0);
    #1;
    chk("ld_lat2_valid", 64'(bus.mem_result_valid_o), 1);
    cycle();

    // Faulting requests: same-cycle ready with exception, never reach OBI.
    bus.obi_gnt_i = 1;
    req(0, 32'h1000_0002, 0, 4, 4'hF, 0); #1;
    chk("mis_ld_ready", 64'(bus.mem_ready_o), 1);
    chk("mis_ld_exc", 64'(bus.mem_resp_exc_o), 1);
    chk("mis_ld_code", 64'(bus.mem_resp_exccode_o), 4);
    chk("mis_ld_req", 64'(bus.obi_req_o), 0);
    req(0, 32'h0FFF_FFFC, 1, 4, 4'hF, 0); #1;
    chk("oor_lo_st_code", 64'(bus.mem_resp_exccode_o), 7);
    chk("oor_lo_st_req", 64'(bus.obi_req_o), 0);
    req(0, 32'h1000_0001, 1, 2, 4'h3, 0); #1;
    chk("mis_h_st_code", 64'(bus.mem_resp_exccode_o), 6);
    req(0, 32'h1001_0000, 0, 1, 4'h1, 0); #1;
    chk("oor_hi_ld_code", 64'(bus.mem_resp_exccode_o), 5);
    req(0, 32'h0FFF_FFFE, 0, 3, 4'h1, 0); #1;
    chk("bad_size_code", 64'(bus.mem_resp_exccode_o), 4);
    bus.obi_gnt_i = 0;
    req(0, 32'h1000_FFFF, 0, 1, 4'h8, 0); #1;
    chk("edge_hi_exc", 64'(bus.mem_resp_exc_o), 0);
    chk("edge_hi_req", 64'(bus.obi_req_o), 1);
    chk("edge_hi_nogrant_ready", 64'(bus.mem_ready_o), 0);
    cycle();
    idle();
    cycle();
    chk("fault_no_result", 64'(bus.mem_result_valid_o), 0);

    // Outstanding limit: third load stalls until a response frees a slot.
    bus.obi_gnt_i = 1;
    req(1, 32'h1000_0010, 0, 4, 4'hF, 0); #1;
    chk("q1_ready", 64'(bus.mem_ready_o), 1);
    sb.push_back('{4'd1, 32'hA1A1_0001, 1'b0});
    cycle();
    req(2, 32'h1000_0014, 0, 4, 4'hF, 0); #1;
    chk("q2_ready", 64'(bus.mem_ready_o), 1);
    sb.push_back('{4'd2, 32'hA2A2_0002, 1'b0});
    cycle();
    req(3, 32'h1000_0018, 0, 4, 4'hF, 0); #1;
    chk("q3_stall_ready", 64'(bus.mem_ready_o), 0);
    chk("q3_stall_req", 64'(bus.obi_req_o), 0);
    cycle();
    rsp(1, 32'hA1A1_0001, 0); #1;
    chk("q3_popcycle_ready", 64'(bus.mem_ready_o), 0);
    cycle();
    rsp(0, 0, 0); #1;
    chk("q3_ready", 64'(bus.mem_ready_o), 1);
    sb.push_back('{4'd3, 32'hA3A3_0003, 1'b0});
    cycle();
    bus.mem_valid_i = 0;
    rsp(1, 32'hA2A2_0002, 0);
    cycle();
    rsp(1, 32'hA3A3_0003, 0);
    cycle();
    rsp(0, 0, 0);
    cycle();

    // Store with bus error: pass-through fields, zero rdata, err set.
    req(5, 32'h1000_0008, 1, 4, 4'b0011, 32'h1234_5678); #1;
    chk("st_ready", 64'(bus.mem_ready_o), 1);
    chk("st_we", 64'(bus.obi_we_o), 1);
    chk("st_be", 64'(bus.obi_be_o), 64'h3);
    chk("st_wdata", 64'(bus.obi_wdata_o), 64'h1234_5678);
    sb.push_back('{4'd5, 32'd0, 1'b1});
    cycle();
    idle();
    rsp(1, 32'hFFFF_FFFF, 1);
    cycle();
    rsp(0, 0, 0);
    cycle();

    // Spurious response is dropped, sticky until clear_i.
    rsp(1, 32'h5555_5555, 0);
    cycle();
    rsp(0, 0, 0);
    cycle(); cycle();
    chk("spur_set", 64'(bus.spurious_o), 1);
    chk("spur_no_result", 64'(bus.mem_result_valid_o), 0);
    bus.clear_i = 1;
    cycle();
    bus.clear_i = 0;
    chk("spur_cleared", 64'(bus.spurious_o), 0);

    // Reset with two loads in flight: their responses become spurious, new traffic works.
    bus.obi_gnt_i = 1;
    req(6, 32'h1000_0020, 0, 4, 4'hF, 0);
    cycle();
    req(7, 32'h1000_0024, 0, 4, 4'hF, 0);
    cycle();
    idle();
    rst_n = 0;
    cycle();
    rst_n = 1;
    chk("rstmid_valid", 64'(bus.mem_result_valid_o), 0);
    rsp(1, 32'h6666_6666, 0);
    cycle();
    rsp(1, 32'h7777_7777, 0);
    cycle();
    rsp(0, 0, 0);
    chk("rstmid_spurious", 64'(bus.spurious_o), 1);
    bus.obi_gnt_i = 1;
    req(8, 32'h1000_0030, 0, 4, 4'hF, 0); #1;
    chk("post_rst_ready", 64'(bus.mem_ready_o), 1);
    sb.push_back('{4'd8, 32'hC0FF_EE08, 1'b0});
    cycle();
    req(9, 32'h1000_0034, 0, 2, 4'h3, 0); #1;
    chk("post_rst_ready2", 64'(bus.mem_ready_o), 1);
    sb.push_back('{4'd9, 32'hC0FF_EE09, 1'b0});
    cycle();
    idle();
    rsp(1, 32'hC0FF_EE08, 0);
    cycle();
    rsp(1, 32'hC0FF_EE09, 0);
    cycle();
    rsp(0, 0, 0);
    cycle(); cycle();
    chk("sb_drained", 64'(sb.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
